// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if: producer/consumer stream bundle for rr_stream_mux.
// RR_STREAM_MUX_LOCK_EN adds the in_last/out_last packet markers.
interface rr_stream_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int CH_W = $clog2(N_CH);
    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
`ifdef RR_STREAM_MUX_LOCK_EN
    logic [N_CH-1:0]       in_last;
    logic                  out_last;
    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_data, out_ch, out_last);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_data, out_ch, out_last);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_ch);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_ch);
`endif
endinterface

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel round-robin stream mux with a registered output stage.
// RR_STREAM_MUX_LOCK_EN holds the grant on one channel until its in_last beat.
module rr_stream_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    rr_stream_mux_if.slave s
);
    localparam int CH_W = $clog2(N_CH);
    logic [CH_W-1:0]             ptr, gnt_ch, nxt;
    logic [CH_W:0]               sum;
    logic [N_CH-1:0]             cand, rot;
    logic                        gnt_any, load;
    logic [N_CH-1:0][WIDTH-1:0]  din;
    assign din  = s.in_data;
    assign load = ~s.out_valid | s.out_ready;
`ifdef RR_STREAM_MUX_LOCK_EN
    logic locked, last;
    // While locked, ptr holds the owning channel so only it can be granted
    assign cand = locked ? s.in_valid & (N_CH'(1) << ptr) : s.in_valid;
    assign last = s.in_last[gnt_ch];
`else
    assign cand = s.in_valid;
`endif
    assign rot = N_CH'({cand, cand} >> ptr);
    always_comb begin
        gnt_ch  = '0;
        gnt_any = 1'b0;
        sum     = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum     = {1'b0, ptr} + (CH_W+1)'(k);
                gnt_ch  = sum >= (CH_W+1)'(N_CH) ? CH_W'(sum - (CH_W+1)'(N_CH)) : CH_W'(sum);
                gnt_any = 1'b1;
            end
        end
    end
    assign nxt        = gnt_ch == CH_W'(N_CH - 1) ? '0 : gnt_ch + 1'b1;
    assign s.in_ready = (gnt_any & load & ~rst) ? N_CH'(1) << gnt_ch : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_ch    <= '0;
            ptr         <= '0;
`ifdef RR_STREAM_MUX_LOCK_EN
            s.out_last  <= 1'b0;
            locked      <= 1'b0;
`endif
        end else if (load) begin
            s.out_valid <= gnt_any;
            if (gnt_any) begin
                s.out_data <= din[gnt_ch];
                s.out_ch   <= gnt_ch;
`ifdef RR_STREAM_MUX_LOCK_EN
                s.out_last <= last;
                locked     <= ~last;
                ptr        <= last ? nxt : gnt_ch;
`else
                ptr        <= nxt;
`endif
            end
        end
    end
endmodule
